// File: rtl/seq_arith_pkg.sv
// Shared encodings for the sequential add/multiply stage.
// Latency: none (definitions only); backpressure: not applicable.
package seq_arith_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_arith_if.sv
// Request/result handshake bundle between an operand producer and seq_arith_unit.
// Latency: wires only; backpressure: valid/ready on both the request and result sides.
interface seq_arith_if import seq_arith_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic               in_valid;
  logic               in_ready;
  logic               in_op;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic               out_op;
  logic [2*WIDTH-1:0] out_result;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_op, out_result
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_op, out_result
  );

endinterface

// File: rtl/seq_arith_mul_dp.sv
// Shift-add multiplier datapath: one partial-product step per step_i, loaded by start_i.
// Latency: WIDTH steps per product; backpressure: none, the controller gates step_i.
module seq_arith_mul_dp import seq_arith_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_step;

  // acc_o is the accumulator value after the current step, so the controller can
  // capture the finished product on the same edge that performs the last step.
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign acc_o    = acc_step;
  assign last_o   = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential arithmetic stage: add in 1 cycle, shift-add multiply in WIDTH+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module seq_arith_unit import seq_arith_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  seq_arith_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic               out_op_q, out_op_d;
  logic [2*WIDTH-1:0] out_result_q, out_result_d;
  logic [WIDTH:0]     add_sum;
  logic               dp_start, dp_step, dp_last;
  logic [2*WIDTH-1:0] dp_acc;

  seq_arith_mul_dp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul_dp (
    .clk     (clk),
    .reset   (reset),
    .start_i (dp_start),
    .step_i  (dp_step),
    .a_i     (bus.in_a),
    .b_i     (bus.in_b),
    .last_o  (dp_last),
    .acc_o   (dp_acc)
  );

  assign add_sum        = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_op     = out_op_q;
  assign bus.out_result = out_result_q;

  always_comb begin
    state_d      = state_q;
    out_op_d     = out_op_q;
    out_result_d = out_result_q;
    dp_start     = 1'b0;
    dp_step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          out_op_d = bus.in_op;
          if (bus.in_op == OP_MUL) begin
            dp_start = 1'b1;
            state_d  = MUL;
          end else begin
            out_result_d = {{(WIDTH-1){1'b0}}, add_sum};
            state_d      = DONE;
          end
        end
      end
      MUL: begin
        dp_step = 1'b1;
        if (dp_last) begin
          out_result_d = dp_acc;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      out_op_q     <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      out_op_q     <= out_op_d;
      out_result_q <= out_result_d;
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit with a result scoreboard.
// Requests push expected results; each observed result pops and compares.
module tb_seq_arith_unit;
  import seq_arith_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic         op;
    logic [2*W-1:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  seq_arith_if #(.WIDTH(W)) bus ();

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] aa;
    logic [2*W-1:0] bb;
    aa = {{W{1'b0}}, a};
    bb = {{W{1'b0}}, b};
    return (op == OP_MUL) ? aa * bb : aa + bb;
  endfunction

  // Present one request, confirm it is accepted on the next rising edge, then scramble the inputs.
  task automatic do_req(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    check({tag, ":in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, ":op_known"}, 32'($isunknown(bus.in_op)), 32'd0);
    e.op  = op;
    e.res = model(op, a, b);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_op    = ~op;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
  endtask

  // Wait for the result, check latency and value, stall it for 'hold' cycles, then release it.
  task automatic collect(input string tag, input int exp_lat, input int hold, input bit noisy);
    exp_t e;
    int   n;
    bit   seen;
    n    = 0;
    seen = 1'b0;
    e    = sb_q.pop_front();
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        check({tag, ":busy_in_ready"}, 32'(bus.in_ready), 32'd0);
        if (noisy) begin
          bus.in_valid = 1'b1;
          bus.in_op    = 1'($urandom_range(0, 1));
          bus.in_a     = W'($urandom);
          bus.in_b     = W'($urandom);
        end
      end
    end
    bus.in_valid = 1'b0;
    check({tag, ":latency"}, 32'(n), 32'(exp_lat));
    check({tag, ":result"}, 32'(bus.out_result), 32'(e.res));
    check({tag, ":op"}, 32'(bus.out_op), 32'(e.op));
    check({tag, ":done_in_ready"}, 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ":hold_result"}, 32'(bus.out_result), 32'(e.res));
      check({tag, ":hold_op"}, 32'(bus.out_op), 32'(e.op));
      check({tag, ":hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, ":post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ":post_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, ":post_result"}, 32'(bus.out_result), 32'(e.res));
  endtask

  initial begin
    bit stray_valid;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;

    #12;
    check("reset:out_valid", 32'(bus.out_valid), 32'd0);
    check("reset:out_op", 32'(bus.out_op), 32'd0);
    check("reset:out_result", 32'(bus.out_result), 32'd0);
    #5 reset = 1'b0;
    @(negedge clk);
    check("reset:in_ready", 32'(bus.in_ready), 32'd1);

    do_req(OP_ADD, 8'd9, 8'd3, "add_9_3");
    collect("add_9_3", 1, 0, 1'b0);

    do_req(OP_ADD, 8'd255, 8'd1, "add_carry");
    collect("add_carry", 1, 5, 1'b0);

    do_req(OP_MUL, 8'd3, 8'd7, "mul_3_7");
    collect("mul_3_7", W + 1, 0, 1'b1);

    do_req(OP_MUL, 8'd255, 8'd255, "mul_max");
    collect("mul_max", W + 1, 2, 1'b0);

    do_req(OP_MUL, 8'd0, 8'd200, "mul_zero");
    collect("mul_zero", W + 1, 0, 1'b0);

    // Abort a multiply in its 4th iteration cycle; the queued expectation is discarded with it.
    do_req(OP_MUL, 8'd8, 8'd9, "mul_abort");
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort:out_valid", 32'(bus.out_valid), 32'd0);
    check("abort:out_op", 32'(bus.out_op), 32'd0);
    check("abort:out_result", 32'(bus.out_result), 32'd0);
    void'(sb_q.pop_front());
    @(posedge clk);
    #1 reset = 1'b0;
    stray_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stray_valid = 1'b1;
    end
    check("abort:no_result", 32'(stray_valid), 32'd0);
    check("abort:in_ready", 32'(bus.in_ready), 32'd1);

    do_req(OP_ADD, 8'd1, 8'd1, "add_after_rst");
    collect("add_after_rst", 1, 0, 1'b0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
